// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//
// Sequential multiply-accumulate: result = multiplicand * multiplier + addend,
// computed with one shift-and-add step per clock (WIDTH steps), followed by a
// single accumulate cycle. A zero multiplicand takes a short path that skips
// the multiply entirely.
//
// Optional feature macro: MULT_CHECK_EN
//   When defined, adds an "expected" operand that is latched with the others
//   and a "check_ok" flag that reports whether the completed result equals
//   the zero-extended expected value.
//
// Ports
//   clk          in   1         clock, rising edge
//   rst          in   1         synchronous active-high reset
//   start        in   1         request, only sampled while idle
//   multiplicand in   WIDTH     first factor
//   multiplier   in   WIDTH     second factor
//   addend       in   WIDTH     value added to the product
//   busy         out  1         high while multiplying / accumulating
//   valid        out  1         one-cycle pulse when result is final
//   result       out  2*WIDTH   last completed result, held until the next
//   expected     in   WIDTH     (MULT_CHECK_EN only) value to compare with
//   check_ok     out  1         (MULT_CHECK_EN only) result == expected
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   addend,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] result
`ifdef MULT_CHECK_EN
  ,
  input  logic [WIDTH-1:0]   expected,
  output logic               check_ok
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    ADD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   addend_q, addend_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               valid_q, valid_d;
  // Set for one cycle after a zero-multiplicand request, so that its valid
  // pulse arrives one cycle after the sampling edge.
  logic               zpend_q, zpend_d;

  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] final_sum;
  logic               done;

`ifdef MULT_CHECK_EN
  logic [WIDTH-1:0]   expected_q, expected_d;
  logic               check_ok_q, check_ok_d;
`endif

  // Upper half plus (conditionally) the multiplicand, keeping the carry as
  // the new top bit before the right shift.
  assign step_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} +
                     {1'b0, (p_q[0] ? mcand_q : {WIDTH{1'b0}})};
  // The zero-multiplicand path clears P, so this sum is correct for both the
  // normal completion and the short path.
  assign final_sum = p_q + {{WIDTH{1'b0}}, addend_q};
  assign done      = zpend_q || (state_q == ADD);

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    mcand_d  = mcand_q;
    addend_d = addend_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    valid_d  = 1'b0;
    zpend_d  = 1'b0;
`ifdef MULT_CHECK_EN
    expected_d = expected_q;
    check_ok_d = check_ok_q;
`endif

    // Completion uses the current register values; a new request accepted in
    // the same cycle only affects the registers from the next edge onwards.
    if (done) begin
      result_d = final_sum;
      valid_d  = 1'b1;
`ifdef MULT_CHECK_EN
      check_ok_d = (final_sum == {{WIDTH{1'b0}}, expected_q});
`endif
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = multiplicand;
          addend_d = addend;
          cnt_d    = '0;
`ifdef MULT_CHECK_EN
          expected_d = expected;
`endif
          if (multiplicand != '0) begin
            p_d     = {{WIDTH{1'b0}}, multiplier};
            state_d = MULT;
          end else begin
            p_d     = '0;
            zpend_d = 1'b1;
          end
        end
      end
      MULT: begin
        p_d   = {step_sum, p_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ADD;
        end
      end
      ADD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      p_q      <= '0;
      mcand_q  <= '0;
      addend_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      zpend_q  <= 1'b0;
`ifdef MULT_CHECK_EN
      expected_q <= '0;
      check_ok_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      mcand_q  <= mcand_d;
      addend_q <= addend_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      zpend_q  <= zpend_d;
`ifdef MULT_CHECK_EN
      expected_q <= expected_d;
      check_ok_q <= check_ok_d;
`endif
    end
  end

  assign busy   = (state_q == MULT) || (state_q == ADD);
  assign valid  = valid_q;
  assign result = result_q;
`ifdef MULT_CHECK_EN
  assign check_ok = check_ok_q;
`endif

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier (WIDTH = 16). The stimulus process pushes
// the expected result and completion cycle into a scoreboard queue; the
// monitor pops and compares on every valid pulse.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] multiplicand = '0;
  logic [15:0] multiplier = '0;
  logic [15:0] addend = '0;
  logic        busy;
  logic        valid;
  logic [31:0] result;
`ifdef MULT_CHECK_EN
  logic [15:0] expected = '0;
  logic        check_ok;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    bit          ck;
  } exp_t;
  exp_t sb[$];

  shift_add_multiplier #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .busy         (busy),
    .valid        (valid),
    .result       (result)
`ifdef MULT_CHECK_EN
    ,
    .expected     (expected),
    .check_ok     (check_ok)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid cycle=%0d result=%h required=no valid", cyc, result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res) begin
          errors++;
          $display("FAIL result cycle=%0d got=%h required=%h", cyc, result, e.res);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL latency got_cycle=%0d required_cycle=%0d", cyc, e.cyc);
        end
`ifdef MULT_CHECK_EN
        checks++;
        if (check_ok !== e.ck) begin
          errors++;
          $display("FAIL check_ok got=%b required=%b", check_ok, e.ck);
        end
`endif
        $display("txn cycle=%0d result=%h", cyc, result);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Called just after a falling edge; start is sampled on the next rising edge.
  task automatic issue(input logic [15:0] mc, input logic [15:0] ml, input logic [15:0] ad,
                       input logic [15:0] ex, input bit push, input logic [31:0] er,
                       input int lat);
    exp_t e;
    multiplicand = mc;
    multiplier   = ml;
    addend       = ad;
`ifdef MULT_CHECK_EN
    expected     = ex;
`endif
    start = 1'b1;
    if (push) begin
      e.res = er;
      e.cyc = cyc + 1 + lat;
      e.ck  = (er == {16'h0, ex});
      sb.push_back(e);
    end
    @(negedge clk); #1;
    start = 1'b0;
    // Scramble operands while busy; the latched values must be used.
    multiplicand = 16'($urandom);
    multiplier   = 16'($urandom);
    addend       = 16'($urandom);
`ifdef MULT_CHECK_EN
    expected     = 16'($urandom);
`endif
  endtask

  task automatic run_one(input string name, input logic [15:0] mc, input logic [15:0] ml,
                         input logic [15:0] ad, input logic [15:0] ex,
                         input logic [31:0] er, input int lat, input int exp_busy);
    int bc;
    bc = 0;
    issue(mc, ml, ad, ex, 1'b1, er, lat);
    repeat (25) begin
      if (busy) bc++;
      @(negedge clk); #1;
    end
    check({name, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
    check({name, "_result_hold"}, result, er);
  endtask

  initial begin
    bit got;
    rst = 1'b1;
    start = 1'b1;             // reset must win over start
    multiplicand = 16'd3;
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_result", result, 32'd0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk); #1;

    run_one("normal", 16'd7, 16'd14, 16'd2, 16'd100, 32'h0000_0064, 17, 17);
    run_one("maxops", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_0000, 17, 17);
    run_one("zero_mcand", 16'd0, 16'd5, 16'h1234, 16'h1234, 32'h0000_1234, 1, 0);
    run_one("shifted", 16'h1234, 16'h0010, 16'h0005, 16'h0000, 32'h0001_2345, 17, 17);
    run_one("pow2", 16'h8000, 16'h0002, 16'h0000, 16'h0000, 32'h0001_0000, 17, 17);
    run_one("mult_zero", 16'h00FF, 16'h0000, 16'h0042, 16'h0042, 32'h0000_0042, 17, 17);
    run_one("check_bad", 16'd7, 16'd14, 16'd2, 16'd101, 32'h0000_0064, 17, 17);

    // Start while busy: second request five cycles later must be ignored.
    issue(16'd3, 16'd5, 16'd1, 16'd16, 1'b1, 32'h0000_0010, 17);
    repeat (4) begin @(negedge clk); #1; end
    multiplicand = 16'd9; multiplier = 16'd9; addend = 16'd9;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (25) begin @(negedge clk); #1; end
    check("busy_start_drained", 32'(sb.size()), 32'd0);
    check("busy_start_result", result, 32'h0000_0010);

    // Reset at cycle 8 of an operation: no valid may follow.
    issue(16'd7, 16'd14, 16'd2, 16'd100, 1'b0, 32'd0, 17);
    repeat (7) begin @(negedge clk); #1; end
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_result", result, 32'd0);
    repeat (25) begin @(negedge clk); #1; end
    run_one("after_abort", 16'd7, 16'd14, 16'd2, 16'd100, 32'h0000_0064, 17, 17);

    // Start in the cycle valid is high must be accepted.
    issue(16'd2, 16'd3, 16'd4, 16'd10, 1'b1, 32'h0000_000A, 17);
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    check("b2b_first_valid_seen", {31'd0, got}, 32'd1);
    issue(16'd5, 16'd6, 16'd7, 16'd37, 1'b1, 32'h0000_0025, 17);
    repeat (25) begin @(negedge clk); #1; end
    check("b2b_drained", 32'(sb.size()), 32'd0);
    check("b2b_result", result, 32'h0000_0025);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
